vertex_feeder: RTL

VERTEX_FEEDER -- requirements
Module: vertex_feeder

---
 rtl/vertex_feeder_pkg.sv | 26 ++
 rtl/vertex_feeder_if.sv | 38 +++
 rtl/vertex_feeder_bram_read_pipe.sv | 40 ++++
 rtl/vertex_feeder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/vertex_feeder_pkg.sv
// Shared types for the vertex feeder and the distance unit it drives:
// coordinate/distance words, feeder FSM states and address-width helper.
package vertex_feeder_pkg;

    localparam int COORD_W = 32;
    localparam int DIST_W  = 32;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [DIST_W-1:0]  dist_t;

    localparam dist_t DIST_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        UPDATE,
        DONE
    } feeder_state_e;

    // Width of an index over n entries; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vertex_feeder_if.sv
// Coordinate BRAM read port plus the feeder <-> distance unit handshake.
interface vertex_feeder_if #(
    parameter int DIM          = 2,
    parameter int NUM_VERTICES = 64
);
    import vertex_feeder_pkg::*;

    localparam int ADDR_W = addr_w(NUM_VERTICES * DIM);

    logic [ADDR_W-1:0]           bram_addr_out;
    coord_t                      bram_data_in;
    logic [DIM-1:0][COORD_W-1:0] vertex_pos_out;
    logic [DIM-1:0][COORD_W-1:0] query_pos_out;
    logic [DIM-1:0]              data_valid_out;
    dist_t                       distance_sq_in;
    logic                        distance_valid_in;

    modport master (
        output bram_addr_out,
        output vertex_pos_out,
        output query_pos_out,
        output data_valid_out,
        input  bram_data_in,
        input  distance_sq_in,
        input  distance_valid_in
    );

    modport slave (
        input  bram_addr_out,
        input  vertex_pos_out,
        input  query_pos_out,
        input  data_valid_out,
        output bram_data_in,
        output distance_sq_in,
        output distance_valid_in
    );

endinterface

// File: rtl/vertex_feeder_bram_read_pipe.sv
// Tracks outstanding BRAM reads: a valid bit and dimension tag delayed by the
// BRAM latency so read data can be steered to the right coordinate slot.
module bram_read_pipe #(
    parameter int BRAM_LATENCY = 2,
    parameter int TAG_W        = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             issue_vld,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             cap_vld,
    output logic [TAG_W-1:0] cap_tag
);

    logic [BRAM_LATENCY-1:0]            vld_p;
    logic [BRAM_LATENCY-1:0][TAG_W-1:0] tag_p;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue_vld;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Tags are only meaningful alongside a set valid bit.
    always_ff @(posedge clk_in) begin
        tag_p[0] <= issue_tag;
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            tag_p[i] <= tag_p[i-1];
        end
    end

    assign cap_vld = vld_p[BRAM_LATENCY-1];
    assign cap_tag = tag_p[BRAM_LATENCY-1];

endmodule

// File: rtl/vertex_feeder.sv
// Scans every stored vertex, feeds it with the latched query to an external
// squared-distance unit, and keeps the nearest vertex id and its distance.
module vertex_feeder
    import vertex_feeder_pkg::*;
#(
    parameter int DIM          = 2,
    parameter int NUM_VERTICES = 64,
    parameter int BRAM_LATENCY = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           start_in,
    input  logic [DIM-1:0][COORD_W-1:0]    query_pos_in,
    vertex_feeder_if.master                vf_bus,
    output logic [addr_w(NUM_VERTICES)-1:0] best_id_out,
    output dist_t                          best_dist_out,
    output logic                           busy_out,
    output logic                           done_out,
    output logic                           timeout_out
);

    localparam int ID_W   = addr_w(NUM_VERTICES);
    localparam int ADDR_W = addr_w(NUM_VERTICES * DIM);
    localparam int TAG_W  = addr_w(DIM);
    localparam int ISS_W  = $clog2(DIM + 1);
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_VERTICES - 1);
    localparam logic [ADDR_W-1:0] DIM_A     = ADDR_W'(DIM);
    localparam logic [ISS_W-1:0]  DIM_I     = ISS_W'(DIM);
    localparam logic [TAG_W-1:0]  LAST_TAG  = TAG_W'(DIM - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

    feeder_state_e     state, state_nxt;
    logic [ID_W-1:0]   vtx_cnt;
    logic [ISS_W-1:0]  iss_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    dist_t             dist_q;

    logic              issue_vld;
    logic [TAG_W-1:0]  issue_tag;
    logic              cap_vld;
    logic [TAG_W-1:0]  cap_tag;
    logic              last_cap;
    logic              dist_hit;
    logic              wait_expired;

    assign issue_vld    = (state == FETCH) && (iss_cnt < DIM_I);
    assign issue_tag    = TAG_W'(iss_cnt);
    assign last_cap     = cap_vld && (cap_tag == LAST_TAG);
    assign dist_hit     = (state == WAIT) && vf_bus.distance_valid_in;
    assign wait_expired = (state == WAIT) && !vf_bus.distance_valid_in &&
                          (wait_cnt == WAIT_LAST);

    // Coordinate d of vertex v lives at v*DIM + d.
    assign vf_bus.bram_addr_out = ADDR_W'(vtx_cnt) * DIM_A + ADDR_W'(iss_cnt);

    bram_read_pipe #(
        .BRAM_LATENCY (BRAM_LATENCY),
        .TAG_W        (TAG_W)
    ) u_read_pipe (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .issue_vld (issue_vld),
        .issue_tag (issue_tag),
        .cap_vld   (cap_vld),
        .cap_tag   (cap_tag)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt             = state;
        busy_out              = 1'b1;
        done_out              = 1'b0;
        vf_bus.data_valid_out = '0;
        unique case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (start_in) state_nxt = FETCH;
            end
            FETCH: begin
                if (last_cap) state_nxt = WAIT;
            end
            WAIT: begin
                vf_bus.data_valid_out = '1;
                if (dist_hit)          state_nxt = UPDATE;
                else if (wait_expired) state_nxt = DONE;
            end
            UPDATE: begin
                state_nxt = (vtx_cnt == LAST_ID) ? DONE : FETCH;
            end
            DONE: begin
                done_out  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vtx_cnt               <= '0;
            iss_cnt               <= '0;
            wait_cnt              <= '0;
            dist_q                <= '0;
            best_id_out           <= '0;
            best_dist_out         <= '0;
            timeout_out           <= 1'b0;
            vf_bus.query_pos_out  <= '0;
            vf_bus.vertex_pos_out <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        vf_bus.query_pos_out <= query_pos_in;
                        vtx_cnt              <= '0;
                        iss_cnt              <= '0;
                        best_dist_out        <= DIST_MAX;
                        best_id_out          <= '0;
                        timeout_out          <= 1'b0;
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    if (issue_vld) iss_cnt <= iss_cnt + ISS_W'(1);
                end
                WAIT: begin
                    if (dist_hit) begin
                        dist_q <= vf_bus.distance_sq_in;
                    end else if (wait_expired) begin
                        timeout_out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                UPDATE: begin
                    // Strict compare: an equal later vertex never displaces the lower id.
                    if (dist_q < best_dist_out) begin
                        best_dist_out <= dist_q;
                        best_id_out   <= vtx_cnt;
                    end
                    if (vtx_cnt != LAST_ID) vtx_cnt <= vtx_cnt + ID_W'(1);
                    iss_cnt <= '0;
                end
                default: ;
            endcase

            if (cap_vld) vf_bus.vertex_pos_out[cap_tag] <= vf_bus.bram_data_in;
        end
    end

endmodule
